// File: rtl/bus_pkg.sv
// Shared definitions for the serial address/valid system bus: FSM state encodings,
// default address width and the number of populated slaves.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_ACKW = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  localparam int DEVICE_ADDR_WIDTH_DEF = 4;
  localparam int NUM_SLAVES            = 3;

  // Bit counter must hold the longest in-state count without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, LSB-first shift-out register. o_bit is the next bit to emit; asserting
// i_shift together with i_load emits din[0] in the load cycle and keeps the rest.
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_src;

  // Select between freshly loaded data and the held remainder.
  always_comb begin
    w_src = r_data;
    if (i_load) begin
      w_src = i_din;
    end else begin
      w_src = r_data;
    end
  end

  assign o_bit = w_src[0];

  // Shift register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= {WIDTH{1'b0}};
    end else if (i_shift) begin
      r_data <= w_src >> 1;
    end else if (i_load) begin
      r_data <= w_src;
    end else begin
      r_data <= r_data;
    end
  end

endmodule

// File: rtl/master_req_tx.sv
// Master-side bus initiator: sends the device address LSB-first, samples the decoder's
// one-cycle ack window, then sends the payload LSB-first or aborts with an error pulse.
module master_req_tx
  import bus_pkg::*;
#(
  parameter int DEVICE_ADDR_WIDTH = DEVICE_ADDR_WIDTH_DEF,
  parameter int PAYLOAD_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [DEVICE_ADDR_WIDTH-1:0] req_dev,
  input  logic [PAYLOAD_WIDTH-1:0]     req_payload,
  output logic                         mwdata,
  output logic                         mvalid,
  input  logic                         ack,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int CNT_W = cnt_width(DEVICE_ADDR_WIDTH, PAYLOAD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(DEVICE_ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_WIDTH - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mvalid;
  logic             r_mwdata;
  logic             r_done;
  logic             r_err;

  logic w_accept;
  logic w_addr_shift;
  logic w_pay_shift;
  logic w_addr_bit;
  logic w_pay_bit;

  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign w_accept     = req_valid & req_ready;
  assign w_addr_shift = w_accept | (r_state == ST_ADDR);
  assign w_pay_shift  = ((r_state == ST_ACKW) & ack) | (r_state == ST_DATA);

  assign mwdata = r_mwdata;
  assign mvalid = r_mvalid;
  assign done   = r_done;
  assign err    = r_err;

  piso_shift #(.WIDTH(DEVICE_ADDR_WIDTH)) u_addr_sr (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_accept),
    .i_shift (w_addr_shift),
    .i_din   (req_dev),
    .o_bit   (w_addr_bit)
  );

  piso_shift #(.WIDTH(PAYLOAD_WIDTH)) u_pay_sr (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_accept),
    .i_shift (w_pay_shift),
    .i_din   (req_payload),
    .o_bit   (w_pay_bit)
  );

  // Transaction FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_mvalid <= 1'b0;
      r_mwdata <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= CNT_ZERO;
          if (w_accept) begin
            r_state  <= ST_ADDR;
            r_mvalid <= 1'b1;
            r_mwdata <= w_addr_bit;
          end else begin
            r_mvalid <= 1'b0;
            r_mwdata <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (r_cnt == ADDR_LAST) begin
            r_state  <= ST_ACKW;
            r_cnt    <= CNT_ZERO;
            r_mwdata <= 1'b0;
          end else begin
            r_cnt    <= r_cnt + CNT_ONE;
            r_mwdata <= w_addr_bit;
          end
        end
        // The decoder's verdict is only meaningful in this single cycle.
        ST_ACKW: begin
          r_cnt <= CNT_ZERO;
          if (ack) begin
            r_state  <= ST_DATA;
            r_mwdata <= w_pay_bit;
          end else begin
            r_state  <= ST_GAP;
            r_mvalid <= 1'b0;
            r_mwdata <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == DATA_LAST) begin
            r_state  <= ST_GAP;
            r_cnt    <= CNT_ZERO;
            r_mvalid <= 1'b0;
            r_mwdata <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt    <= r_cnt + CNT_ONE;
            r_mwdata <= w_pay_bit;
          end
        end
        ST_GAP: begin
          r_state  <= ST_IDLE;
          r_cnt    <= CNT_ZERO;
          r_mvalid <= 1'b0;
          r_mwdata <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= CNT_ZERO;
          r_mvalid <= 1'b0;
          r_mwdata <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/master_req_tx.md
Name: master_req_tx

Overview:
Master-side initiator for the serial system-bus address/valid protocol; the counterpart of the slave-select address decoder.
- Accepts a parallel request: target device address plus payload.
- Serialises the device address LSB-first on mwdata with mvalid high, then checks the decoder's one-cycle ack window.
- On ack, serialises the payload LSB-first; on no ack, aborts and flags an error.
- Sits between a master core and the bus mux/decoder.

Parameters:
DEVICE_ADDR_WIDTH, 4, width of device (slave-select) address, sent first
PAYLOAD_WIDTH, 16, bits sent after ack (memory address/data as packed by master core); must be >= 1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; combinational, = (state==IDLE)
req_dev  in  DEVICE_ADDR_WIDTH  target device address
req_payload  in  PAYLOAD_WIDTH  payload, sent LSB-first
mwdata  out  1  serial bus write data (registered)
mvalid  out  1  bus valid (registered)
ack  in  1  acknowledgement from address decoder
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse: payload fully sent
err  out  1  one-cycle pulse: no ack in ack window

Behaviour:
- Reset (async, rstn=0): state=IDLE, mvalid=0, mwdata=0, done=0, err=0, bit counter=0, shift regs=0. req_ready=1 and busy=0 during and after reset.
- Accept: req_valid & req_ready sampled at the posedge ending cycle T. req_dev and req_payload are captured into internal shift registers.
- Input changes after acceptance have no effect. req_valid in non-IDLE states is ignored.
- States: IDLE, ADDR, ACKW, DATA, GAP.
- IDLE -> ADDR on accept.
- ADDR: cycles T+1..T+DEVICE_ADDR_WIDTH. mvalid=1, mwdata=req_dev[i] in cycle T+1+i. Exits to ACKW after the last bit.
- ACKW: exactly one cycle (T+DEVICE_ADDR_WIDTH+1). mvalid=1, mwdata=0. ack sampled at the end of this cycle.
  - ack=1 -> DATA.
  - ack=0 -> GAP with err.
- ack in any state other than ACKW is ignored.
- DATA: PAYLOAD_WIDTH cycles. mvalid=1, mwdata=payload[j] in the j-th DATA cycle. After the last bit -> GAP with done.
- GAP: exactly one cycle, mvalid=0, mwdata=0 -> IDLE.
  - done or err is 1 in the GAP cycle only; never both.
  - Guarantees mvalid is low for at least 2 cycles between transactions (GAP + IDLE accept cycle), so the decoder returns to IDLE.
- Latency (defaults, accept at T): address bits T+1..T+4, ack window T+5, payload T+6..T+21, done at T+22, req_ready=1 at T+23, next mvalid at T+24 at the earliest.
- Error path: mvalid=0 and err=1 at T+5+... i.e. cycle T+DEVICE_ADDR_WIDTH+2. No payload bits are sent.
- Counter: width $clog2 of max(DEVICE_ADDR_WIDTH, PAYLOAD_WIDTH)+1. Cleared on each state entry; no wrap within a state.
- Reset mid-transaction: mvalid/mwdata drop to 0 immediately (async). No done/err pulse. Transaction discarded.
- mvalid never toggles within a transaction from first address bit to last payload bit.

Decomposition:
- Shared package (bus_pkg): state encodings IDLE/ADDR/ACKW/DATA/GAP; DEVICE_ADDR_WIDTH default; number of valid slaves (3) for bench use.
- One sub-module: piso_shift (parallel-load, LSB-first shift-out register, parameter WIDTH, async active-low reset). Instantiated twice: device address and payload.

Test Plan:
1. req_dev=4'b0010, req_payload=16'hA5C3, ack=1 at T+5:
   - mvalid=1 T+1..T+21.
   - mwdata = 0,1,0,0 at T+1..T+4, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at T+6..T+21.
   - mvalid=0 and done=1 at T+22; req_ready=1 at T+23.
2. req_dev=4'b0011 (invalid slave), ack=0 at T+5: mvalid=0 at T+6, err=1 at T+6, done stays 0, no payload bits, IDLE at T+7.
3. ack=1 only at T+3 (early), 0 at T+5: early ack ignored; err=1 at T+6; no DATA state entered.
4. req_valid held high with two requests (dev 0, then dev 1): second accept at T+23; mvalid low T+22..T+23; second device address starts at T+24.
5. rstn low asynchronously at T+10 (mid-DATA): mvalid=0 and mwdata=0 within the same cycle; no done/err pulse; req_ready=1; a new request after release completes normally.
6. req_dev/req_payload changed and req_valid pulsed during busy: serial output matches originally captured values; second request not accepted.
